exu_flush_req: RTL
==================

Name: exu_flush_req

Overview:
- Initiator side of the EXU flush interface.
- Accepts flush requests from branch/jump resolution and owns the free-running cycle_cnt.
- Drives the 2-bit flush code and flush target PC so the flush-stall controller samples them exactly once, at the sample count.
- Buffers one pending request while a flush is in flight, and tracks the controller's flush_stall to know when the interface is free.

Parameters:
- CNT_W, 4, width of cycle_cnt.
- CNT_MAX, 7, terminal value of cycle_cnt; it wraps to 0 after this value.
- SAMPLE_CNT, 4, cycle_cnt value at which the consumer samples flush.
- PC_W, 32, width of the flush target PC.

Ports:
- hclk  in  1  clock.
- hrstn  in  1  asynchronous active-low reset.
- run_en  in  1  advances cycle_cnt; a sample event needs run_en=1.
- req_valid  in  1  flush request valid.
- req_type  in  2  1=FLUSH_CYCLE_1 (short), 2=FLUSH_CYCLE_2 (long); 0 and 3 are illegal.
- req_pc  in  PC_W  redirect target.
- req_ready  out  1  request can be accepted.
- flush_stall  in  1  registered stall output from the flush-stall controller.
- cycle_cnt  out  CNT_W  phase counter fed to the consumer.
- flush  out  2  flush code to the consumer.
- flush_pc  out  PC_W  target associated with the active flush.
- flush_busy  out  1  request active or pending.
- bad_req  out  1  sticky flag: an illegal req_type was seen.

Behaviour:
- Reset (async, hrstn=0): cycle_cnt=0, flush=0, flush_pc=0, state=IDLE, pending slot empty, bad_req=0.
  - req_ready reads 1 once reset is released.
  - Reset mid-flush discards both the active and the pending request.
- cycle_cnt: +1 per clock while run_en=1; CNT_MAX wraps to 0; holds while run_en=0.
- Sample event (SE): run_en=1 && cycle_cnt==SAMPLE_CNT, on the current-cycle value.
- Accept: req_valid && req_ready && req_type∈{1,2}.
  - req_type 0 or 3 with req_valid: no accept, no state change, bad_req<=1 (sticky until reset).
- req_ready = !pend_vld (registered state only; no combinational path from req_valid).
- State machine on the active slot {act_type, act_pc}:
  - IDLE: flush=0.
    - If pend_vld: move pending into active, clear pending, go ARMED.
    - Else if accept: load the request directly into active (bypass), go ARMED.
  - ARMED: flush=act_type, flush_pc=act_pc, driven from registers.
    - On SE: go HOLD; flush becomes 0 in the next cycle, so it is sampled exactly once.
    - Without SE: flush is held stable.
  - HOLD: flush=0, flush_pc holds its last value.
    - The consumer raises flush_stall the cycle after SE.
    - Leave when flush_stall==0: to ARMED (loading pending) if pend_vld, else to IDLE.
    - HOLD lasts at least 1 cycle.
- Pending slot, ARMED/HOLD with pend empty: an accept writes pending.
- Pending slot, IDLE with pend_vld: the move happens; req_ready=0 that cycle, so there is no collision.
- Latency: an accept in IDLE gives flush valid on the next cycle.
  - It is sampled at the first SE after that; if cycle_cnt==SAMPLE_CNT on the very next cycle, that SE counts.
- flush_busy = (state!=IDLE) || pend_vld.
- flush_stall=1 while IDLE (consumer desync): ignored; a new flush is still issued.

Optional Feature:
- Macro FLUSH_REQ_MERGE_EN.
- When defined: with pend_vld=1, req_ready stays 1. An accept overwrites pending with pc=req_pc, type=max(pend_type, req_type). A long flush is never downgraded and the newest target wins.
- When undefined: req_ready=!pend_vld as above, and a second request back-pressures.

Test Plan:
- Reset: hold hrstn=0 mid-count at cycle_cnt=5 -> all outputs 0 immediately (async), req_ready=1 after release.
- Short flush: run_en=1, request type1 pc=0x100 at cycle_cnt=1 -> flush=1 and flush_pc=0x100 from cnt=2 through cnt=4, flush=0 at cnt=5.
  - Model flush_stall=1 for one cycle, then busy=0.
- Long flush: type2 pc=0x200 -> flush=2 held until SE; state stays HOLD while the modelled stall spans two SEs, then returns to IDLE.
- Pending: type1 pc=0x10 followed by type2 pc=0x20 while ARMED -> req_ready=0 until HOLD exits; the second flush issues pc=0x20 at the next SE; no third accept.
- run_en=0 while ARMED at cycle_cnt=4 -> no SE, flush held stable; run_en=1 -> sampled, flush=0 next cycle.
- Illegal type3 -> not accepted, bad_req=1 sticky.
  - With FLUSH_REQ_MERGE_EN: pending type2, then type1 pc=0x30 -> issued type2 pc=0x30.

Source files
------------

// File: rtl/exu_flush_req.sv
`default_nettype none
// ============================================================================
//  Module   : exu_flush_req
//  Brief    : Initiator side of the EXU flush interface. Owns the free-running
//             cycle counter, presents one flush code/target per request so the
//             flush-stall controller samples it exactly once at SAMPLE_CNT,
//             and buffers a single pending request while a flush is in flight.
//  Options  : FLUSH_REQ_MERGE_EN - keep req_ready high while a request is
//             pending and merge new requests into the pending slot
//             (type = max of both, newest target wins).
//  Revision : 1.0 - initial release
// ============================================================================
module exu_flush_req #(
   parameter int CNT_W      = 4,
   parameter int CNT_MAX    = 7,
   parameter int SAMPLE_CNT = 4,
   parameter int PC_W       = 32
) (
   input  logic              hclk_i,
   input  logic              hrstn_i,
   input  logic              run_en_i,
   input  logic              req_valid_i,
   input  logic [1:0]        req_type_i,
   input  logic [PC_W-1:0]   req_pc_i,
   output logic              req_ready_o,
   input  logic              flush_stall_i,
   output logic [CNT_W-1:0]  cycle_cnt_o,
   output logic [1:0]        flush_o,
   output logic [PC_W-1:0]   flush_pc_o,
   output logic              flush_busy_o,
   output logic              bad_req_o
);

   localparam logic [CNT_W-1:0] c_CNT_MAX    = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0] c_SAMPLE_CNT = CNT_W'(SAMPLE_CNT);
   localparam logic [1:0]       c_TYPE_NONE  = 2'd0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [1:0]         flush_q;     // doubles as the active request type
   logic [PC_W-1:0]    act_pc_q;
   logic               pend_vld_q;
   logic [1:0]         pend_type_q;
   logic [PC_W-1:0]    pend_pc_q;
   logic               bad_req_q;

   logic               w_se;
   logic               w_legal;
   logic               w_ready;
   logic               w_accept;
   logic               w_bypass;
   logic               w_move;
   logic [1:0]         w_merge_type;

   // Sample event uses the current-cycle counter value
   assign w_se    = run_en_i && (cnt_q == c_SAMPLE_CNT);
   assign w_legal = (req_type_i == 2'd1) || (req_type_i == 2'd2);

`ifdef FLUSH_REQ_MERGE_EN
   assign w_ready = 1'b1;
`else
   assign w_ready = !pend_vld_q;
`endif

   assign w_accept = req_valid_i && w_ready && w_legal;

   // An accept in IDLE with nothing pending goes straight to the active slot
   assign w_bypass = (state_q == S_IDLE) && !pend_vld_q;

   // Pending request is promoted to active this cycle
   assign w_move = pend_vld_q &&
                   ((state_q == S_IDLE) || ((state_q == S_HOLD) && !flush_stall_i));

   // A long flush must never be downgraded by a later short one
   assign w_merge_type = (req_type_i > pend_type_q) ? req_type_i : pend_type_q;

   // Free-running phase counter, wraps after CNT_MAX, frozen while run_en is low
   always_ff @(posedge hclk_i or negedge hrstn_i) begin
      if (!hrstn_i) begin
         cnt_q <= '0;
      end else if (run_en_i) begin
         if (cnt_q == c_CNT_MAX) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // Active-slot state machine; flush code and target are registered here
   always_ff @(posedge hclk_i or negedge hrstn_i) begin
      if (!hrstn_i) begin
         state_q  <= S_IDLE;
         flush_q  <= c_TYPE_NONE;
         act_pc_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pend_vld_q) begin
                  state_q  <= S_ARMED;
                  flush_q  <= pend_type_q;
                  act_pc_q <= pend_pc_q;
               end else if (w_accept) begin
                  state_q  <= S_ARMED;
                  flush_q  <= req_type_i;
                  act_pc_q <= req_pc_i;
               end
            end
            S_ARMED: begin
               // Drop the code right after the sample so it is seen only once
               if (w_se) begin
                  state_q <= S_HOLD;
                  flush_q <= c_TYPE_NONE;
               end
            end
            S_HOLD: begin
               if (!flush_stall_i) begin
                  if (pend_vld_q) begin
                     state_q  <= S_ARMED;
                     flush_q  <= pend_type_q;
                     act_pc_q <= pend_pc_q;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               flush_q <= c_TYPE_NONE;
            end
         endcase
      end
   end

   // Single-entry pending buffer: fill, merge, or drain on promotion
   always_ff @(posedge hclk_i or negedge hrstn_i) begin
      if (!hrstn_i) begin
         pend_vld_q  <= 1'b0;
         pend_type_q <= c_TYPE_NONE;
         pend_pc_q   <= '0;
      end else if (w_accept && !w_bypass) begin
         pend_vld_q <= 1'b1;
         pend_pc_q  <= req_pc_i;
         if (pend_vld_q && !w_move) begin
            pend_type_q <= w_merge_type;
         end else begin
            pend_type_q <= req_type_i;
         end
      end else if (w_move) begin
         pend_vld_q <= 1'b0;
      end
   end

   // Sticky flag for any request carrying an illegal type code
   always_ff @(posedge hclk_i or negedge hrstn_i) begin
      if (!hrstn_i) begin
         bad_req_q <= 1'b0;
      end else if (req_valid_i && !w_legal) begin
         bad_req_q <= 1'b1;
      end
   end

   assign req_ready_o  = w_ready;
   assign cycle_cnt_o  = cnt_q;
   assign flush_o      = flush_q;
   assign flush_pc_o   = act_pc_q;
   assign flush_busy_o = (state_q != S_IDLE) || pend_vld_q;
   assign bad_req_o    = bad_req_q;

endmodule
`default_nettype wire
